// File: rtl/acc_job_arbiter_pkg.sv
// Shared types and defaults for the accelerator job arbiter and the register-map block.
package acc_ctrl_pkg;

  localparam int ACC_ARB_NREQ_DEF    = 4;
  localparam int ACC_ARB_TIMEOUT_DEF = 1024;
  localparam int ACC_ARB_CNT_W_DEF   = 32;

  // Same encoding is decoded by the register map to report an idle core
  localparam logic [1:0] ACC_ARB_IDLE = 2'b00;

  typedef enum logic [1:0] {
    ARB_IDLE  = ACC_ARB_IDLE,
    ARB_START = 2'b01,
    ARB_WAIT  = 2'b10,
    ARB_DONE  = 2'b11
  } acc_arb_state_t;

endpackage

// File: rtl/acc_job_arbiter_if.sv
// Requester and core-side handshake bundle of acc_job_arbiter.
interface acc_job_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 32
);
  logic [NREQ-1:0]  i_req;
  logic [NREQ-1:0]  o_gnt;
  logic [NREQ-1:0]  o_done;
  logic [NREQ-1:0]  o_err;
  logic             o_acc_start;
  logic             i_acc_finish;
  logic             o_busy;
  logic [CNT_W-1:0] o_cycles;

  modport slave (
    input  i_req, i_acc_finish,
    output o_gnt, o_done, o_err, o_acc_start, o_busy, o_cycles
  );

  modport master (
    output i_req, i_acc_finish,
    input  o_gnt, o_done, o_err, o_acc_start, o_busy, o_cycles
  );
endinterface

// File: rtl/acc_job_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after last_ptr, with wrap-around.
module acc_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IDX_W'((32'(last_ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/acc_job_arbiter.sv
// Round-robin job arbiter/sequencer in front of custom_acc_top start/finish pins.
// Optional watchdog on the WAIT phase: define ACC_JOB_ARBITER_TIMEOUT_EN.
import acc_ctrl_pkg::*;

module acc_job_arbiter #(
  parameter int NREQ         = ACC_ARB_NREQ_DEF,
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = ACC_ARB_TIMEOUT_DEF,
  parameter int CNT_W        = ACC_ARB_CNT_W_DEF
) (
  input logic               clk,
  input logic               reset,
  acc_job_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || START_CYCLES < 1 || START_CYCLES > 255 ||
      TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
    $error("acc_job_arbiter: parameter out of range");
  end

  acc_arb_state_t   state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic [7:0]       start_cnt_q, start_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic             finish_q;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic [CNT_W-1:0] cnt_inc;
  logic             finish_edge;
  logic             timeout_hit;

  acc_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req      (bus.i_req),
    .last_ptr (last_ptr_q),
    .gnt      (pick_gnt),
    .gnt_idx  (pick_idx)
  );

  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign finish_edge = bus.i_acc_finish & ~finish_q;

`ifdef ACC_JOB_ARBITER_TIMEOUT_EN
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  // Grant clears and done pulses on the same edge, so done is its own register
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    last_ptr_d  = last_ptr_q;
    start_cnt_d = start_cnt_q;
    cnt_d       = cnt_q;
    cycles_d    = cycles_q;
    done_d      = '0;
    err_d       = '0;
    case (state_q)
      ARB_IDLE: begin
        if (|bus.i_req) begin
          gnt_d       = pick_gnt;
          gnt_idx_d   = pick_idx;
          start_cnt_d = '0;
          state_d     = ARB_START;
        end
      end
      ARB_START: begin
        if (start_cnt_q == 8'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ARB_WAIT;
        end else begin
          start_cnt_d = start_cnt_q + 8'd1;
        end
      end
      ARB_WAIT: begin
        cnt_d = cnt_inc;
        if (finish_edge || timeout_hit) begin
          done_d     = gnt_q;
          err_d      = finish_edge ? '0 : gnt_q;
          cycles_d   = cnt_inc;
          last_ptr_d = gnt_idx_q;
          gnt_d      = '0;
          state_d    = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      last_ptr_q  <= IDX_W'(NREQ - 1);
      start_cnt_q <= '0;
      cnt_q       <= '0;
      cycles_q    <= '0;
      done_q      <= '0;
      err_q       <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      last_ptr_q  <= last_ptr_d;
      start_cnt_q <= start_cnt_d;
      cnt_q       <= cnt_d;
      cycles_q    <= cycles_d;
      done_q      <= done_d;
      err_q       <= err_d;
      finish_q    <= bus.i_acc_finish;
    end
  end

  assign bus.o_gnt       = gnt_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;
  assign bus.o_acc_start = (state_q == ARB_START);
  assign bus.o_busy      = (state_q != ARB_IDLE);
  assign bus.o_cycles    = cycles_q;

endmodule

// File: tb/tb_acc_job_arbiter.sv
// Directed bench for acc_job_arbiter (NREQ=4, START_CYCLES=1, TIMEOUT=16).
module tb_acc_job_arbiter;

  localparam int NREQ         = 4;
  localparam int START_CYCLES = 1;
  localparam int TMO          = 16;
  localparam int CNT_W        = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #10 clk = ~clk;

  acc_job_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus_if ();

  acc_job_arbiter #(
    .NREQ(NREQ), .START_CYCLES(START_CYCLES), .TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset               = 1'b0;
    bus_if.i_req        = '0;
    bus_if.i_acc_finish = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n = 0;
    @(negedge clk);
    while (bus_if.o_gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s gnt", tag), 32'(bus_if.o_gnt), 32'(exp));
    check($sformatf("%s start", tag), 32'(bus_if.o_acc_start), 32'd1);
  endtask

  task automatic start_phase(input string tag);
    int n = 0;
    while (bus_if.o_acc_start && n < 300) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("%s start width", tag), 32'(n), 32'(START_CYCLES));
  endtask

  // Entered at the negedge of WAIT cycle 1; finish rises so it is seen in WAIT cycle fin
  task automatic finish_phase(input string tag, input int fin, input logic [3:0] exp_gnt,
                              input logic [31:0] exp_cyc, input bit drop, input bit keep);
    repeat (fin - 1) @(negedge clk);
    check($sformatf("%s no early done", tag), 32'(bus_if.o_done), 32'd0);
    bus_if.i_acc_finish = 1'b1;
    @(negedge clk);
    check($sformatf("%s done", tag), 32'(bus_if.o_done), 32'(exp_gnt));
    check($sformatf("%s err", tag), 32'(bus_if.o_err), 32'd0);
    check($sformatf("%s cycles", tag), bus_if.o_cycles, exp_cyc);
    check($sformatf("%s gnt clear", tag), 32'(bus_if.o_gnt), 32'd0);
    if (drop) bus_if.i_req = bus_if.i_req & ~exp_gnt;
    if (!keep) bus_if.i_acc_finish = 1'b0;
    @(negedge clk);
    check($sformatf("%s done pulse", tag), 32'(bus_if.o_done), 32'd0);
    check($sformatf("%s idle busy", tag), 32'(bus_if.o_busy), 32'd0);
  endtask

  initial begin
    logic [3:0] fair_exp [4];
    fair_exp = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    bus_if.i_req        = '0;
    bus_if.i_acc_finish = 1'b0;

    repeat (3) @(negedge clk);
    check("rst gnt",    32'(bus_if.o_gnt),       32'd0);
    check("rst done",   32'(bus_if.o_done),      32'd0);
    check("rst err",    32'(bus_if.o_err),       32'd0);
    check("rst start",  32'(bus_if.o_acc_start), 32'd0);
    check("rst busy",   32'(bus_if.o_busy),      32'd0);
    check("rst cycles", bus_if.o_cycles,         32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle no req busy", 32'(bus_if.o_busy), 32'd0);

    bus_if.i_req = 4'b0001;
    wait_grant("single", 4'b0001);
    check("single busy", 32'(bus_if.o_busy), 32'd1);
    start_phase("single");
    finish_phase("single", 5, 4'b0001, 32'd5, 1'b1, 1'b0);

    do_reset();
    bus_if.i_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("cont%0d", k), 4'(1 << k));
      start_phase($sformatf("cont%0d", k));
      finish_phase($sformatf("cont%0d", k), k + 1, 4'(1 << k), 32'(k + 1), 1'b1, 1'b0);
    end

    do_reset();
    bus_if.i_req = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("fair%0d", k), fair_exp[k]);
      start_phase($sformatf("fair%0d", k));
      finish_phase($sformatf("fair%0d", k), 2, fair_exp[k], 32'd2, 1'b0, 1'b0);
    end

    do_reset();
    bus_if.i_req = 4'b0001;
    wait_grant("stale1", 4'b0001);
    start_phase("stale1");
    finish_phase("stale1", 3, 4'b0001, 32'd3, 1'b1, 1'b1);
    bus_if.i_req = 4'b0001;
    wait_grant("stale2", 4'b0001);
    start_phase("stale2");
    repeat (3) @(negedge clk);
    check("stale held no done", 32'(bus_if.o_done), 32'd0);
    check("stale held busy", 32'(bus_if.o_busy), 32'd1);
    bus_if.i_acc_finish = 1'b0;
    @(negedge clk);
    check("stale low no done", 32'(bus_if.o_done), 32'd0);
    bus_if.i_acc_finish = 1'b1;
    @(negedge clk);
    check("stale2 done", 32'(bus_if.o_done), 32'd1);
    check("stale2 cycles", bus_if.o_cycles, 32'd5);
    bus_if.i_req        = '0;
    bus_if.i_acc_finish = 1'b0;
    @(negedge clk);

`ifdef ACC_JOB_ARBITER_TIMEOUT_EN
    bus_if.i_req = 4'b0001;
    wait_grant("tmo", 4'b0001);
    start_phase("tmo");
    repeat (TMO - 1) @(negedge clk);
    check("tmo no early done", 32'(bus_if.o_done), 32'd0);
    @(negedge clk);
    check("tmo done", 32'(bus_if.o_done), 32'd1);
    check("tmo err", 32'(bus_if.o_err), 32'd1);
    check("tmo cycles", bus_if.o_cycles, 32'(TMO));
    bus_if.i_req = '0;
    @(negedge clk);
`endif

    do_reset();
    bus_if.i_req = 4'b1000;
    wait_grant("abort", 4'b1000);
    start_phase("abort");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst gnt",    32'(bus_if.o_gnt),       32'd0);
    check("midrst start",  32'(bus_if.o_acc_start), 32'd0);
    check("midrst busy",   32'(bus_if.o_busy),      32'd0);
    check("midrst done",   32'(bus_if.o_done),      32'd0);
    check("midrst cycles", bus_if.o_cycles,         32'd0);
    bus_if.i_req = 4'b0100;
    @(negedge clk);
    reset = 1'b1;
    check("release done", 32'(bus_if.o_done), 32'd0);
    wait_grant("post_rst", 4'b0100);
    check("post_rst done", 32'(bus_if.o_done), 32'd0);
    start_phase("post_rst");
    finish_phase("post_rst", 2, 4'b0100, 32'd2, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
